// File: rtl/axi4_lite_master_rw.sv
// axi4_lite_master_rw: single-outstanding AXI4-Lite master turning one local read/write request into AXI handshakes
// Optional feature macro: AXI4_LITE_MASTER_WSTRB_EN adds the req_wstrb port; without it every byte lane is written.
module axi4_lite_master_rw #(
   parameter int addr_width = 7,
   parameter int data_width = 32
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      req_valid,
   output logic                      req_ready,
   input  logic                      req_write,
   input  logic [addr_width-1:0]     req_addr,
   input  logic [data_width-1:0]     req_wdata,
`ifdef AXI4_LITE_MASTER_WSTRB_EN
   input  logic [data_width/8-1:0]   req_wstrb,
`endif
   output logic                      resp_valid,
   output logic                      resp_error,
   output logic [data_width-1:0]     resp_rdata,
   output logic [addr_width-1:0]     m_axi_awaddr,
   output logic [2:0]                m_axi_awprot,
   output logic                      m_axi_awvalid,
   input  logic                      m_axi_awready,
   output logic [data_width-1:0]     m_axi_wdata,
   output logic [data_width/8-1:0]   m_axi_wstrb,
   output logic                      m_axi_wvalid,
   input  logic                      m_axi_wready,
   input  logic [1:0]                m_axi_bresp,
   input  logic                      m_axi_bvalid,
   output logic                      m_axi_bready,
   output logic [addr_width-1:0]     m_axi_araddr,
   output logic [2:0]                m_axi_arprot,
   output logic                      m_axi_arvalid,
   input  logic                      m_axi_arready,
   input  logic [data_width-1:0]     m_axi_rdata,
   input  logic [1:0]                m_axi_rresp,
   input  logic                      m_axi_rvalid,
   output logic                      m_axi_rready
);
   typedef enum logic [2:0] {IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA} state_t;
   state_t state, next;
   logic [addr_width-1:0] addr_q;
   logic [data_width-1:0] wdata_q;
   logic aw_done, w_done;
   logic unused_resp;
   wire aw_hs = m_axi_awvalid && m_axi_awready;
   wire w_hs = m_axi_wvalid && m_axi_wready;
   wire accept = req_valid && req_ready;
   assign m_axi_awaddr = addr_q;
   assign m_axi_araddr = addr_q;
   assign m_axi_wdata = wdata_q;
   assign m_axi_awprot = 3'b000;
   assign m_axi_arprot = 3'b000;
   assign unused_resp = m_axi_bresp[0] ^ m_axi_rresp[0];
`ifdef AXI4_LITE_MASTER_WSTRB_EN
   logic [data_width/8-1:0] wstrb_q;
   assign m_axi_wstrb = wstrb_q;
   // strobes are captured with the request so the W channel stays stable until its handshake
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) wstrb_q <= '0;
      else if (accept) wstrb_q <= req_wstrb;
`else
   assign m_axi_wstrb = '1;
`endif
   // state register
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else state <= next;
   // next state: write leaves WR_ADDR_DATA once both AW and W have handshaked, in either order
   always_comb begin
      next = state;
      case (state)
         IDLE:         next = req_valid ? (req_write ? WR_ADDR_DATA : RD_ADDR) : IDLE;
         WR_ADDR_DATA: next = (aw_done || aw_hs) && (w_done || w_hs) ? WR_RESP : WR_ADDR_DATA;
         WR_RESP:      next = m_axi_bvalid ? IDLE : WR_RESP;
         RD_ADDR:      next = m_axi_arready ? RD_DATA : RD_ADDR;
         RD_DATA:      next = m_axi_rvalid ? IDLE : RD_DATA;
         default:      next = IDLE;
      endcase
   end
   // handshake outputs decoded purely from state so no valid ever depends on a ready
   always_comb begin
      req_ready     = state == IDLE;
      m_axi_awvalid = state == WR_ADDR_DATA && !aw_done;
      m_axi_wvalid  = state == WR_ADDR_DATA && !w_done;
      m_axi_bready  = state == WR_RESP;
      m_axi_arvalid = state == RD_ADDR;
      m_axi_rready  = state == RD_DATA;
   end
   // request capture, per-channel done flags and the registered completion pulse
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         addr_q     <= '0;
         wdata_q    <= '0;
         aw_done    <= 1'b0;
         w_done     <= 1'b0;
         resp_valid <= 1'b0;
         resp_error <= 1'b0;
         resp_rdata <= '0;
      end else begin
         resp_valid <= 1'b0;
         if (accept) begin
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
         end
         if (aw_hs) aw_done <= 1'b1;
         if (w_hs) w_done <= 1'b1;
         if (state == WR_RESP && m_axi_bvalid) begin
            resp_valid <= 1'b1;
            resp_error <= m_axi_bresp[1];
         end
         if (state == RD_DATA && m_axi_rvalid) begin
            resp_valid <= 1'b1;
            resp_error <= m_axi_rresp[1];
            resp_rdata <= m_axi_rdata;
         end
      end
endmodule

// File: tb/tb_axi4_lite_master_rw.sv
// tb_axi4_lite_master_rw: scoreboard bench with a delay-programmable AXI4-Lite slave and a memory reference model
module tb_axi4_lite_master_rw;
   logic clk, rst_n;
   logic req_valid, req_ready, req_write;
   logic [6:0] req_addr;
   logic [31:0] req_wdata;
   logic [3:0] req_wstrb;
   logic resp_valid, resp_error;
   logic [31:0] resp_rdata;
   logic [6:0] m_axi_awaddr, m_axi_araddr;
   logic [2:0] m_axi_awprot, m_axi_arprot;
   logic m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
   logic [31:0] m_axi_wdata, m_axi_rdata;
   logic [3:0] m_axi_wstrb;
   logic [1:0] m_axi_bresp, m_axi_rresp;
   logic m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready, m_axi_rvalid, m_axi_rready;

   axi4_lite_master_rw dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata),
`ifdef AXI4_LITE_MASTER_WSTRB_EN
      .req_wstrb(req_wstrb),
`endif
      .resp_valid(resp_valid), .resp_error(resp_error), .resp_rdata(resp_rdata),
      .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
      .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
      .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
      .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
      .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
   );

   initial clk = 0;
   always #5 clk = ~clk;

   int n_tests = 0, n_fail = 0;
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // reference model: register file addressed by the full address; 0x70.. is an error region
   typedef struct {bit wr; bit err; logic [31:0] rdata;} exp_t;
   exp_t exp_q[$];
   exp_t mon_e;
   logic [31:0] mmem [128];
   logic [31:0] last_rd = 0;
   logic [6:0] cur_addr;
   logic [31:0] cur_wdata;
   logic [3:0] cur_strb;

   // slave-side storage and pacing
   logic [31:0] smem [128];
   bit fixed_mode = 1;
   int fx [5] = '{0, 0, 0, 0, 0};
   int aw_wait, w_wait, b_wait, ar_wait, r_wait;
   bit aw_busy, w_busy, b_busy, ar_busy, r_busy;
   bit have_aw, have_w, have_ar, b_fire, r_fire;
   bit p_awv, p_wv, p_arv;
   logic [6:0] s_awaddr, s_araddr, p_awaddr, p_araddr;
   logic [31:0] s_wdata, p_wdata;
   logic [3:0] s_wstrb, p_wstrb;
   logic [6:0] atab [16] = '{7'h00, 7'h01, 7'h02, 7'h03, 7'h04, 7'h05, 7'h12, 7'h3F,
                             7'h5F, 7'h60, 7'h61, 7'h6F, 7'h70, 7'h71, 7'h7E, 7'h7F};

   function automatic int dly(input int ch);
      return fixed_mode ? fx[ch] : int'($urandom_range(0, 3));
   endfunction

   // AXI slave: decides at each falling edge what it presents for the next rising edge
   always @(negedge clk) begin
      if (!rst_n) begin
         m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0; m_axi_bresp = 0;
         m_axi_arready = 0; m_axi_rvalid = 0; m_axi_rresp = 0; m_axi_rdata = 0;
         {aw_busy, w_busy, b_busy, ar_busy, r_busy} = 0;
         {have_aw, have_w, have_ar, b_fire, r_fire, p_awv, p_wv, p_arv} = 0;
      end else begin
         if (p_awv) begin
            if (m_axi_awready) chk("aw_drop", m_axi_awvalid, 0);
            else chk("aw_hold", {m_axi_awvalid, m_axi_awaddr}, {1'b1, p_awaddr});
         end
         if (p_wv) begin
            if (m_axi_wready) chk("w_drop", m_axi_wvalid, 0);
            else chk("w_hold", {m_axi_wvalid, m_axi_wstrb, m_axi_wdata}, {1'b1, p_wstrb, p_wdata});
         end
         if (p_arv) begin
            if (m_axi_arready) chk("ar_drop", m_axi_arvalid, 0);
            else chk("ar_hold", {m_axi_arvalid, m_axi_araddr}, {1'b1, p_araddr});
         end
         p_awv = m_axi_awvalid; p_awaddr = m_axi_awaddr;
         p_wv = m_axi_wvalid; p_wdata = m_axi_wdata; p_wstrb = m_axi_wstrb;
         p_arv = m_axi_arvalid; p_araddr = m_axi_araddr;
         if (b_fire) begin m_axi_bvalid = 0; b_fire = 0; end
         if (have_aw && have_w && !m_axi_bvalid) begin
            if (!b_busy) begin b_busy = 1; b_wait = dly(2); end
            if (b_wait == 0) begin
               b_busy = 0; have_aw = 0; have_w = 0; m_axi_bvalid = 1;
               m_axi_bresp = s_awaddr >= 7'h70 ? 2'b11 : s_awaddr >= 7'h60 ? 2'b01 : 2'b00;
               if (!m_axi_bresp[1])
                  for (int b = 0; b < 4; b++) if (s_wstrb[b]) smem[s_awaddr][8*b+:8] = s_wdata[8*b+:8];
            end else b_wait--;
         end
         b_fire = m_axi_bvalid && m_axi_bready;
         if (r_fire) begin m_axi_rvalid = 0; r_fire = 0; end
         if (have_ar && !m_axi_rvalid) begin
            if (!r_busy) begin r_busy = 1; r_wait = dly(4); end
            if (r_wait == 0) begin
               r_busy = 0; have_ar = 0; m_axi_rvalid = 1;
               m_axi_rresp = s_araddr >= 7'h70 ? 2'b10 : s_araddr >= 7'h60 ? 2'b01 : 2'b00;
               m_axi_rdata = m_axi_rresp[1] ? 32'hBAD0_BAD0 : smem[s_araddr];
            end else r_wait--;
         end
         r_fire = m_axi_rvalid && m_axi_rready;
         m_axi_awready = 0;
         if (m_axi_awvalid && !have_aw) begin
            if (!aw_busy) begin aw_busy = 1; aw_wait = dly(0); end
            if (aw_wait == 0) begin
               aw_busy = 0; have_aw = 1; m_axi_awready = 1; s_awaddr = m_axi_awaddr;
               chk("awaddr", {m_axi_awprot, m_axi_awaddr}, {3'b000, cur_addr});
            end else aw_wait--;
         end
         m_axi_wready = 0;
         if (m_axi_wvalid && !have_w) begin
            if (!w_busy) begin w_busy = 1; w_wait = dly(1); end
            if (w_wait == 0) begin
               w_busy = 0; have_w = 1; m_axi_wready = 1; s_wdata = m_axi_wdata; s_wstrb = m_axi_wstrb;
               chk("wdata_wstrb", {m_axi_wstrb, m_axi_wdata}, {cur_strb, cur_wdata});
            end else w_wait--;
         end
         m_axi_arready = 0;
         if (m_axi_arvalid && !have_ar) begin
            if (!ar_busy) begin ar_busy = 1; ar_wait = dly(3); end
            if (ar_wait == 0) begin
               ar_busy = 0; have_ar = 1; m_axi_arready = 1; s_araddr = m_axi_araddr;
               chk("araddr", {m_axi_arprot, m_axi_araddr}, {3'b000, cur_addr});
            end else ar_wait--;
         end
      end
   end

   // scoreboard monitor: every completion pulse is matched against the oldest expectation
   always @(negedge clk) begin
      if (rst_n && resp_valid) begin
         chk("ready_with_resp", req_ready, 1);
         if (exp_q.size() == 0) chk("resp_unexpected", 1, 0);
         else begin
            mon_e = exp_q.pop_front();
            chk(mon_e.wr ? "wr_resp_error" : "rd_resp_error", resp_error, mon_e.err);
            chk(mon_e.wr ? "wr_resp_rdata_hold" : "rd_resp_rdata", resp_rdata, mon_e.rdata);
         end
      end
   end

   task automatic send(input bit wr, input logic [6:0] a, input logic [31:0] d, input logic [3:0] s);
      int n = 0;
      exp_t e;
      req_valid = 1; req_write = wr; req_addr = a; req_wdata = d; req_wstrb = s;
      while (!req_ready && n < 200) begin @(negedge clk); n++; end
      if (!req_ready) begin
         chk("req_accept_timeout", 0, 1);
         req_valid = 0;
         return;
      end
`ifdef AXI4_LITE_MASTER_WSTRB_EN
      cur_strb = s;
`else
      cur_strb = 4'hF;
`endif
      cur_addr = a; cur_wdata = d;
      e.wr = wr;
      e.err = a >= 7'h70;
      if (wr) begin
         if (!e.err) for (int b = 0; b < 4; b++) if (cur_strb[b]) mmem[a][8*b+:8] = d[8*b+:8];
         e.rdata = last_rd;
      end else begin
         last_rd = e.err ? 32'hBAD0_BAD0 : mmem[a];
         e.rdata = last_rd;
      end
      exp_q.push_back(e);
      @(negedge clk);
      req_valid = 0;
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 300) begin @(negedge clk); n++; end
      if (exp_q.size() != 0) begin
         chk("drain_timeout", 64'(exp_q.size()), 0);
         exp_q.delete();
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   logic wr_r;
   logic [6:0] a_r;
   initial begin
      rst_n = 0; req_valid = 0; req_write = 0; req_addr = 0; req_wdata = 0; req_wstrb = 0;
      for (int i = 0; i < 128; i++) begin smem[i] = 32'h1000_0000 + i; mmem[i] = 32'h1000_0000 + i; end
      smem[4] = 32'hCAFE_0001; mmem[4] = 32'hCAFE_0001;
      repeat (3) @(negedge clk);
      chk("rst_ctrl", {req_ready, m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready, resp_valid, resp_error}, 8'b1000_0000);
      chk("rst_data", {resp_rdata, m_axi_wdata}, 64'h0);
`ifdef AXI4_LITE_MASTER_WSTRB_EN
      chk("rst_addr_prot_strb", {m_axi_awaddr, m_axi_araddr, m_axi_awprot, m_axi_arprot, m_axi_wstrb}, 24'h0);
`else
      chk("rst_addr_prot_strb", {m_axi_awaddr, m_axi_araddr, m_axi_awprot, m_axi_arprot, m_axi_wstrb}, 24'h00000F);
`endif
      rst_n = 1;
      @(negedge clk);
      // zero-wait write
      send(1, 7'h12, 32'hDEAD_BEEF, 4'hF);
      chk("t1_c1_valids", {m_axi_awvalid, m_axi_wvalid, m_axi_bready}, 3'b110);
      @(negedge clk);
      chk("t1_c2_bready", {m_axi_awvalid, m_axi_wvalid, m_axi_bready, resp_valid}, 4'b0010);
      @(negedge clk);
      chk("t1_c3_resp", {resp_valid, req_ready, resp_error}, 3'b110);
      drain();
      // W accepted four cycles after AW
      fx = '{0, 4, 0, 0, 0};
      send(1, 7'h20, 32'h0123_4567, 4'hF);
      chk("t2_c1_valids", {m_axi_awvalid, m_axi_wvalid}, 2'b11);
      for (int k = 2; k <= 5; k++) begin
         @(negedge clk);
         chk("t2_w_waiting", {m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_wdata}, {3'b010, 32'h0123_4567});
      end
      @(negedge clk);
      chk("t2_c6_wr_resp", {m_axi_awvalid, m_axi_wvalid, m_axi_bready}, 3'b001);
      drain();
      // read with five wait cycles on R
      fx = '{0, 0, 0, 0, 5};
      send(0, 7'h04, 32'h0, 4'hF);
      chk("t3_c1_arvalid", {m_axi_arvalid, m_axi_rready}, 2'b10);
      for (int k = 2; k <= 7; k++) begin
         @(negedge clk);
         chk("t3_rready_held", {m_axi_arvalid, m_axi_rready, resp_valid}, 3'b010);
      end
      @(negedge clk);
      chk("t3_c8_resp", {resp_valid, resp_rdata}, {1'b1, 32'hCAFE_0001});
      @(negedge clk);
      chk("t3_c9_single_pulse", resp_valid, 0);
      drain();
      // error and EXOKAY responses, read-after-write, strobes
      fx = '{0, 0, 0, 0, 0};
      send(0, 7'h70, 32'h0, 4'hF);
      send(1, 7'h71, 32'h5555_AAAA, 4'hF);
      send(1, 7'h60, 32'h6060_6060, 4'hF);
      send(0, 7'h60, 32'h0, 4'hF);
      send(0, 7'h12, 32'h0, 4'hF);
      send(1, 7'h30, 32'hA5A5_A5A5, 4'b0101);
      send(0, 7'h30, 32'h0, 4'hF);
      send(0, 7'h7F, 32'h0, 4'hF);
      drain();
      // reset while waiting in WR_RESP
      fx = '{0, 0, 6, 0, 0};
      send(1, 7'h75, 32'h7575_7575, 4'hF);
      @(negedge clk);
      chk("t5_in_wr_resp", m_axi_bready, 1);
      #2 rst_n = 0;
      #1 chk("t5_async_reset", {m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready, resp_valid, resp_rdata}, 39'h0);
      exp_q.delete();
      last_rd = 0;
      repeat (2) @(negedge clk);
      rst_n = 1;
      @(negedge clk);
      chk("t5_ready_after_release", {req_ready, resp_valid}, 2'b10);
      repeat (8) @(negedge clk);
      // randomized traffic with random slave delays and back-to-back requests
      fixed_mode = 0;
      for (int i = 0; i < 150; i++) begin
         wr_r = 1'($urandom_range(0, 1));
         a_r = atab[$urandom_range(0, 15)];
         send(wr_r, a_r, $urandom, 4'($urandom));
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      drain();
      repeat (4) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
